// File: rtl/mdr_unit_if.sv
// mdr_unit_if: data and control bundle between the datapath and the MDR.
// q_par exists only when MDR_PARITY_EN is defined.
interface mdr_unit_if #(
  parameter int WIDTH = 32
);
  logic             read;
  logic             MDRin;
  logic [WIDTH-1:0] Mdatain;
  logic [WIDTH-1:0] BusMuxOut;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
`ifdef MDR_PARITY_EN
  logic             q_par;

  modport master (
    output read, MDRin, Mdatain, BusMuxOut,
    input  d, q, q_par
  );

  modport slave (
    input  read, MDRin, Mdatain, BusMuxOut,
    output d, q, q_par
  );
`else
  modport master (
    output read, MDRin, Mdatain, BusMuxOut,
    input  d, q
  );

  modport slave (
    input  read, MDRin, Mdatain, BusMuxOut,
    output d, q
  );
`endif
endinterface

// File: rtl/mdr_unit.sv
// mdr_unit: memory data register slice (2:1 input mux + load/clear register).
// Define MDR_PARITY_EN to add the registered even-parity output q_par.
module mdr_mux2 #(
  parameter int WIDTH = 32
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);
  // The unselected leg never reaches y, so X on it is isolated.
  assign y = sel ? a : b;
endmodule

module mdr_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (en) data_d = din;
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) data_q <= '0;
    else        data_q <= data_d;
  end

  assign dout = data_q;
endmodule

module mdr_unit #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        clr,
  mdr_unit_if.slave   bus
);
  logic [WIDTH-1:0] mux_y;

  mdr_mux2 #(.WIDTH(WIDTH)) u_mux (
    .sel (bus.read),
    .a   (bus.Mdatain),
    .b   (bus.BusMuxOut),
    .y   (mux_y)
  );

  mdr_reg #(.WIDTH(WIDTH)) u_reg (
    .clk   (clk),
    .clr_n (clr),
    .en    (bus.MDRin),
    .din   (mux_y),
    .dout  (bus.q)
  );

  assign bus.d = mux_y;

`ifdef MDR_PARITY_EN
  logic par_in;

  // Parity of the word being loaded, captured alongside q.
  assign par_in = ^mux_y;

  mdr_reg #(.WIDTH(1)) u_par (
    .clk   (clk),
    .clr_n (clr),
    .en    (bus.MDRin),
    .din   (par_in),
    .dout  (bus.q_par)
  );
`endif
endmodule

// File: tb/tb_mdr_unit.sv
// tb_mdr_unit: scoreboard bench for mdr_unit, directed plus random stimulus.
// Build with MDR_PARITY_EN defined to also check q_par.
module tb_mdr_unit;
  logic clk;
  logic clr;

  mdr_unit_if #(.WIDTH(32)) bus ();

  mdr_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] d;
    logic [31:0] q;
    logic        p;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mq = '0;

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  function automatic logic even_par(input logic [31:0] w);
    return logic'($countones(w) % 2);
  endfunction

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic step(input logic c, input logic r, input logic e,
                      input logic [31:0] md, input logic [31:0] bm);
    exp_t x;
    @(negedge clk);
    clr           = c;
    bus.read      = r;
    bus.MDRin     = e;
    bus.Mdatain   = md;
    bus.BusMuxOut = bm;
    x.d = r ? md : bm;
    if (!c)     mq = '0;
    else if (e) mq = x.d;
    x.q = mq;
    x.p = even_par(mq);
    sb.push_back(x);
  endtask

  // Monitor: compare outputs just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("d", bus.d, e.d);
        chk("q", bus.q, e.q);
`ifdef MDR_PARITY_EN
        chk("q_par", {31'b0, bus.q_par}, {31'b0, e.p});
`endif
      end
    end
  end

  initial begin
    logic [31:0] xw;
    xw            = 'x;
    clr           = 1'b0;
    bus.read      = 1'bx;
    bus.MDRin     = 1'bx;
    bus.Mdatain   = 'x;
    bus.BusMuxOut = 'x;
    #5;
    chk("reset_q", bus.q, 32'h0);
`ifdef MDR_PARITY_EN
    chk("reset_par", {31'b0, bus.q_par}, 32'h0);
`endif

    // Power-up loads and parity.
    step(1, 1, 1, 32'h8000_0001, 32'h0);
    step(1, 1, 1, 32'h0000_0007, 32'h0);

    // Memory load, then mid-cycle async clear.
    step(1, 1, 1, 32'd15, 32'h1234_5678);
    @(negedge clk);
    #5;
    clr = 1'b0;
    #1;
    chk("async_clr_q", bus.q, 32'h0);
`ifdef MDR_PARITY_EN
    chk("async_clr_par", {31'b0, bus.q_par}, 32'h0);
`endif
    mq = '0;
    step(0, 1, 1, 32'hA5A5_A5A5, 32'h0);
    step(0, 0, 1, 32'h0, 32'h5A5A_5A5A);

    // Bus load with memory data undriven.
    step(1, 0, 1, xw, 32'd30);

    // Hold over five edges.
    for (int i = 0; i < 5; i++)
      step(1, i[0], 0, 32'hFFFF_FFFF, (i % 2 == 0) ? 32'hFFFF_FFFF : $urandom);

    // Clear coincident with a loading edge.
    @(negedge clk);
    bus.read      = 1'b1;
    bus.MDRin     = 1'b1;
    bus.Mdatain   = 32'hDEAD_BEEF;
    bus.BusMuxOut = 32'h0;
    @(posedge clk);
    clr = 1'b0;
    #1;
    chk("race_d", bus.d, 32'hDEAD_BEEF);
    chk("race_q", bus.q, 32'h0);
    mq = '0;

    // Random traffic.
    for (int i = 0; i < 300; i++)
      step(($urandom % 8) != 0, 1'($urandom), 1'($urandom),
           $urandom, $urandom);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
